// File: rtl/serial_deserializer8.sv
// Serial-to-parallel receiver: assembles WIDTH strobed serial bits into a word and
// hands it to a consumer over a valid/ack handshake, flagging bits lost while a word waits.
module serial_deserializer8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     data_ack,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic [$clog2(WIDTH):0]   bit_count,
  output logic                     overrun,
  output logic [1:0]               state_dbg
);

  // Handshake: data_out is valid and held while data_valid=1; the word is consumed on
  // the rising edge where data_ack=1, and data_valid drops on that same edge.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], serial_in};
    else           sr_next = {serial_in, sr[WIDTH-1:1]};
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      data_out   <= '0;
      bit_count  <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            sr        <= '0;
            bit_count <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          // A restart wins over a simultaneous strobe: that bit belongs to no frame.
          if (start) begin
            sr        <= '0;
            bit_count <= '0;
          end else if (bit_valid) begin
            if (bit_count == LAST) begin
              data_out   <= sr_next;
              data_valid <= 1'b1;
              bit_count  <= '0;
              busy       <= 1'b0;
              state      <= WAIT_ACK;
            end else begin
              sr        <= sr_next;
              bit_count <= bit_count + 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (data_ack) begin
            data_valid <= 1'b0;
            if (start) begin
              state     <= SHIFT;
              sr        <= '0;
              bit_count <= '0;
              busy      <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (bit_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
